// File: rtl/alu_cmd_master_if.sv
// ALU serial command bus: two-beat opcode/operand
// stream out, done/result/overflow strobe back.
interface alu_cmd_master_if #(
  parameter int ALU_SIZE = 8
);
  logic                alu_opcode_valid;
  logic                alu_opcode;
  logic [ALU_SIZE-1:0] alu_data;
  logic                alu_done;
  logic [ALU_SIZE-1:0] alu_result;
  logic                alu_overflow;

  modport master (
    output alu_opcode_valid,
    output alu_opcode,
    output alu_data,
    input  alu_done,
    input  alu_result,
    input  alu_overflow
  );

  modport slave (
    input  alu_opcode_valid,
    input  alu_opcode,
    input  alu_data,
    output alu_done,
    output alu_result,
    output alu_overflow
  );
endinterface

// File: rtl/alu_cmd_master.sv
// Serial ALU command initiator: parallel request in,
// two-beat command out, done/timeout response back.
module alu_cmd_master #(
  parameter int ALU_SIZE = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ALU_SIZE-1:0] req_a,
  input  logic [ALU_SIZE-1:0] req_b,
  alu_cmd_master_if.master    alu,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_SIZE-1:0] rsp_result,
  output logic                rsp_overflow,
  output logic                rsp_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                req_ready_q, req_ready_d;
  logic                ov_q, ov_d;
  logic                opc_q, opc_d;
  logic [ALU_SIZE-1:0] data_q, data_d;
  logic                op1_q, op1_d;
  logic [ALU_SIZE-1:0] b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rv_q, rv_d;
  logic [ALU_SIZE-1:0] res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;

  logic accept;
  assign accept = req_valid && req_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      ov_q        <= 1'b0;
      opc_q       <= 1'b0;
      data_q      <= '0;
      op1_q       <= 1'b0;
      b_q         <= '0;
      cnt_q       <= '0;
      rv_q        <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      ov_q        <= ov_d;
      opc_q       <= opc_d;
      data_q      <= data_d;
      op1_q       <= op1_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rv_q        <= rv_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SEND_A;
      SEND_A:  state_d = SEND_B;
      SEND_B:  state_d = WAIT;
      WAIT: begin
        if (alu.alu_done || cnt_q == LAST)
          state_d = RESP;
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rv_d        = (state_d == RESP);
    ov_d        = 1'b0;
    opc_d       = 1'b0;
    data_d      = '0;
    op1_d       = op1_q;
    b_d         = b_q;
    cnt_d       = '0;
    res_d       = res_q;
    ovf_d       = ovf_q;
    to_d        = to_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ov_d   = 1'b1;
          opc_d  = req_op[0];
          data_d = req_a;
          op1_d  = req_op[1];
          b_d    = req_b;
        end
      end
      SEND_A: begin
        ov_d   = 1'b1;
        opc_d  = op1_q;
        data_d = b_q;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (alu.alu_done) begin
          res_d = alu.alu_result;
          ovf_d = alu.alu_overflow;
          to_d  = 1'b0;
        end else if (cnt_q == LAST) begin
          res_d = '0;
          ovf_d = 1'b0;
          to_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready            = req_ready_q;
  assign alu.alu_opcode_valid = ov_q;
  assign alu.alu_opcode       = opc_q;
  assign alu.alu_data         = data_q;
  assign rsp_valid            = rv_q;
  assign rsp_result           = res_q;
  assign rsp_overflow         = ovf_q;
  assign rsp_timeout          = to_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master: vector table
// plus reset and mid-transaction reset sequences.
module tb_alu_cmd_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_overflow;
  logic       rsp_timeout;

  int checks = 0;
  int failures = 0;

  alu_cmd_master_if #(.ALU_SIZE(8)) alu_if ();

  alu_cmd_master #(
    .ALU_SIZE(8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu         (alu_if.master),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         done_k;
    logic       stale;
    int         bp;
    logic [7:0] res;
    logic       ovf;
    logic       b1;
    logic       b2;
    int         lat;
    logic [7:0] e_res;
    logic       e_ovf;
    logic       e_to;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic bus_idle();
    alu_if.alu_done     = 1'b0;
    alu_if.alu_result   = 8'hC3;
    alu_if.alu_overflow = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    tick();
    req_valid = 1'b0;
    req_op    = ~v.op;
    req_a     = ~v.a;
    req_b     = ~v.b;
    chk("beat1_valid", alu_if.alu_opcode_valid, 1);
    chk("beat1_opc", alu_if.alu_opcode, v.b1);
    chk("beat1_data", alu_if.alu_data, v.a);
    chk("beat1_rdy", req_ready, 0);
    tick();
    chk("beat2_valid", alu_if.alu_opcode_valid, 1);
    chk("beat2_opc", alu_if.alu_opcode, v.b2);
    chk("beat2_data", alu_if.alu_data, v.b);
    if (v.stale) begin
      alu_if.alu_done   = 1'b1;
      alu_if.alu_result = 8'h99;
    end
    tick();
    bus_idle();
    chk("wait_valid", alu_if.alu_opcode_valid, 0);
    chk("wait_data", alu_if.alu_data, 0);
    for (n = 3; n < 50; n++) begin
      if (rsp_valid) break;
      if (n - 3 == v.done_k) begin
        alu_if.alu_done     = 1'b1;
        alu_if.alu_result   = v.res;
        alu_if.alu_overflow = v.ovf;
      end
      tick();
      bus_idle();
    end
    chk("rsp_latency", n, v.lat);
    chk("rsp_result", rsp_result, v.e_res);
    chk("rsp_overflow", rsp_overflow, v.e_ovf);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    chk("resp_rdy", req_ready, 0);
    rsp_ready = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      req_valid = 1'b1;
      req_a     = 8'h5A;
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, v.e_res);
      chk("bp_timeout", rsp_timeout, v.e_to);
      chk("bp_rdy", req_ready, 0);
      chk("bp_noaccept", alu_if.alu_opcode_valid, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("done_valid", rsp_valid, 0);
    chk("done_rdy", req_ready, 1);
    chk("done_hold", rsp_result, v.e_res);
  endtask

  initial begin
    //        op     a      b      dk  st  bp res    ov  b1 b2 lat eres   eo e_to
    vt[0] = '{2'b00, 8'h35, 8'h4A, 2,  0,  0, 8'h7F, 0, 0, 0, 6,  8'h7F, 0, 0};
    vt[1] = '{2'b10, 8'hFF, 8'h01, 0,  0,  6, 8'h00, 1, 0, 1, 4,  8'h00, 1, 0};
    vt[2] = '{2'b01, 8'hFF, 8'h01, 1,  0,  0, 8'h00, 1, 1, 0, 5,  8'h00, 1, 0};
    vt[3] = '{2'b11, 8'h12, 8'h34, -1, 0,  2, 8'hAB, 1, 1, 1, 19, 8'h00, 0, 1};
    vt[4] = '{2'b11, 8'h80, 8'h7F, 15, 0,  0, 8'h5A, 1, 1, 1, 19, 8'h5A, 1, 0};
    vt[5] = '{2'b00, 8'h10, 8'h20, 3,  1,  0, 8'h30, 0, 0, 0, 7,  8'h30, 0, 0};

    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 8'h11;
    req_b     = 8'h22;
    rsp_ready = 1'b0;
    bus_idle();
    tick();
    tick();
    chk("rst_opv", alu_if.alu_opcode_valid, 0);
    chk("rst_opc", alu_if.alu_opcode, 0);
    chk("rst_data", alu_if.alu_data, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_ovf", rsp_overflow, 0);
    chk("rst_to", rsp_timeout, 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("post_rst_rdy", req_ready, 1);
    chk("post_rst_opv", alu_if.alu_opcode_valid, 0);

    for (int i = 0; i < 6; i++) run_txn(vt[i]);

    req_valid = 1'b1;
    req_op    = 2'b01;
    req_a     = 8'h01;
    req_b     = 8'h02;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_opv", alu_if.alu_opcode_valid, 0);
    chk("midrst_data", alu_if.alu_data, 0);
    chk("midrst_rspv", rsp_valid, 0);
    chk("midrst_rdy", req_ready, 1);
    reset = 1'b0;
    alu_if.alu_done = 1'b1;
    tick();
    bus_idle();
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (rsp_valid || alu_if.alu_opcode_valid) seen++;
        tick();
      end
      chk("midrst_quiet", seen, 0);
    end
    run_txn(vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
